// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage valid/ready pipeline computing a bitwise logic
// function of two operands, plus registered zero/neg/parity flags and a
// count of delivered results.
module logic_unit_pipe #(
    parameter int WIDTH = 16,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x,
    output logic             zero,
    output logic             neg,
    output logic             parity,
    output logic [CNTW-1:0]  count
);

    // Bitwise operation selected by the 3-bit opcode; B is ignored for ~A.
    function automatic logic [WIDTH-1:0] logic_op(
        input logic [2:0]       f,
        input logic [WIDTH-1:0] l,
        input logic [WIDTH-1:0] r
    );
        logic [WIDTH-1:0] res;
        case (f)
            3'b000:  res = l & r;
            3'b001:  res = l | r;
            3'b010:  res = l ^ r;
            3'b011:  res = ~(l & r);
            3'b100:  res = ~(l | r);
            3'b101:  res = ~(l ^ r);
            3'b110:  res = l & ~r;
            default: res = ~l;
        endcase
        return res;
    endfunction

    // Stage 1 holding registers
    logic             s1_v;
    logic [2:0]       op_p1;
    logic [WIDTH-1:0] a_p1;
    logic [WIDTH-1:0] b_p1;

    logic             s2_rdy;
    logic             in_fire;
    logic             s1_adv;
    logic             out_fire;
    logic [WIDTH-1:0] res_p1;

    // Ready chain and transfer strobes; S2 frees up in the same cycle it drains.
    always_comb begin
        s2_rdy   = !out_valid || out_ready;
        in_ready = !s1_v || s2_rdy;
        in_fire  = in_valid && in_ready;
        s1_adv   = s1_v && s2_rdy;
        out_fire = out_valid && out_ready;
        res_p1   = logic_op(op_p1, a_p1, b_p1);
    end

    // ---- stage 1: capture operands on input transfer ----
    // S1 valid flag: refilled (or emptied) whenever S1 is free or advancing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v <= 1'b0;
        end else if (in_ready) begin
            s1_v <= in_valid;
        end
    end

    // S1 data: loaded only on an accepted beat, so op changes elsewhere are ignored.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            op_p1 <= op;
            a_p1  <= a;
            b_p1  <= b;
        end
    end

    // ---- stage 2: result and flags, held while the consumer stalls ----
    // S2 valid flag follows S1 whenever S2 can accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (s2_rdy) begin
            out_valid <= s1_v;
        end
    end

    // S2 result and flags, reset to the all-zero result's flag values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x      <= '0;
            zero   <= 1'b1;
            neg    <= 1'b0;
            parity <= 1'b0;
        end else if (s1_adv) begin
            x      <= res_p1;
            zero   <= (res_p1 == '0);
            neg    <= res_p1[WIDTH-1];
            parity <= ^res_p1;
        end
    end

    // Delivered-result counter, wrapping naturally at 2^CNTW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (out_fire) begin
            count <= count + {{(CNTW-1){1'b0}}, 1'b1};
        end
    end

endmodule
